// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
//   Shared types and constants for the matrix-vector host sequencer.
//   - seq_state_t   : pass-level FSM states of mv_host_sequencer
//   - drain_phase_t : per-word phases of y_half_drainer
//   - STAT_A/STAT_B : bit positions of the done pulses in pl_status
//   - half_b_base() : byte address of the first word of y half B
// -----------------------------------------------------------------------------
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_A,
        DRAIN,
        WAIT_B,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        RD,
        CAP,
        OUT
    } drain_phase_t;

    localparam int STAT_A = 0;
    localparam int STAT_B = 1;

    localparam logic HALF_A = 1'b0;
    localparam logic HALF_B = 1'b1;

    localparam int LENGTH_M_DEFAULT    = 512;
    localparam int ADDR_Y_SIZE_DEFAULT = 12;

    // Half B starts M/2 words in, i.e. at byte (M/2)*4 = M*2.
    function automatic int half_b_base(input int length_m);
        return length_m * 2;
    endfunction

endpackage

// File: rtl/y_half_drainer.sv
// -----------------------------------------------------------------------------
// y_half_drainer
//   Streams one y half (M/2 words) out of BRAM port B onto AXI4-Stream and
//   zeroes every word as it is handed off, so the accelerator can accumulate
//   into a clean half next time.
// Ports:
//   clk, reset          clock / synchronous active-high reset
//   go                  1-cycle request to drain the half chosen by half_sel
//   half_sel            HALF_A or HALF_B (sampled with go)
//   finished            1-cycle pulse on the handshake of the half's last word
//   bram_*_y_b          BRAM port B (byte address, 1-cycle read latency)
//   m_axis_*            AXI4-Stream master carrying the drained words
// -----------------------------------------------------------------------------
module y_half_drainer
    import mvm_pkg::*;
#(
    parameter int addr_y_size = ADDR_Y_SIZE_DEFAULT,
    parameter int length_M    = LENGTH_M_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic                   half_sel,
    output logic                   finished,
    output logic [addr_y_size-1:0] bram_addr_y_b,
    input  logic [31:0]            bram_rddata_y_b,
    output logic [31:0]            bram_wrdata_y_b,
    output logic [3:0]             bram_we_y_b,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
);

    localparam logic [addr_y_size-1:0] BASE_A = '0;
    localparam logic [addr_y_size-1:0] LAST_A = addr_y_size'((length_M / 2 - 1) * 4);
    localparam logic [addr_y_size-1:0] BASE_B = addr_y_size'(half_b_base(length_M));
    localparam logic [addr_y_size-1:0] LAST_B = addr_y_size'((length_M - 1) * 4);
    localparam logic [addr_y_size-1:0] STEP   = addr_y_size'(4);

    drain_phase_t           phase;
    logic                   active;
    logic                   half_b;
    logic [addr_y_size-1:0] addr;
    logic [31:0]            tdata_q;
    logic                   tvalid_q;

    logic [addr_y_size-1:0] last_addr;
    logic                   at_last;
    logic                   handshake;

    assign last_addr = half_b ? LAST_B : LAST_A;
    assign at_last   = (addr == last_addr);
    assign handshake = active && (phase == OUT) && tvalid_q && m_axis_tready;

    // NOTE: the clearing write must land in the handshake cycle itself, at the
    // address whose word is leaving, so the strobe is combinational off the
    // handshake rather than registered (a register would write one cycle late,
    // after addr has already advanced). Reset masks it so an abort never
    // clears a word that was not delivered.
    assign bram_we_y_b     = (handshake && !reset) ? 4'hf : 4'h0;
    assign bram_wrdata_y_b = 32'h0;
    assign bram_addr_y_b   = addr;
    assign finished        = handshake && at_last && !reset;

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q && at_last;

    // NOTE: every register here uses non-blocking assignment so all of them
    // update together at the edge; blocking assignment would let later
    // statements see half-updated state and break the phase sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= RD;
            active   <= 1'b0;
            half_b   <= HALF_A;
            addr     <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else if (go) begin
            phase    <= RD;
            active   <= 1'b1;
            half_b   <= half_sel;
            addr     <= (half_sel == HALF_B) ? BASE_B : BASE_A;
            tvalid_q <= 1'b0;
        end else if (active) begin
            unique case (phase)
                // Address is already on the port; data appears next cycle.
                RD: phase <= CAP;
                CAP: begin
                    tdata_q  <= bram_rddata_y_b;
                    tvalid_q <= 1'b1;
                    phase    <= OUT;
                end
                // tdata/tvalid hold until the consumer takes the word.
                OUT: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        phase    <= RD;
                        if (at_last) begin
                            active <= 1'b0;
                        end else begin
                            addr <= addr + STEP;
                        end
                    end
                end
                default: phase <= RD;
            endcase
        end
    end

endmodule

// File: rtl/mv_host_sequencer.sv
// -----------------------------------------------------------------------------
// mv_host_sequencer
//   Host-side sequencer for the double-buffered matrix-vector accelerator.
//   Kicks half A / half B computations through ps_control, catches the done
//   pulses on pl_status in sticky flags, drains each finished y half through
//   y_half_drainer, and repeats the A/B pair num_passes times per job.
// Ports:
//   clk, reset          clock / synchronous active-high reset
//   start, num_passes   job request (ignored while busy) and A+B pass count
//   busy, done          job in progress / 1-cycle end-of-job pulse
//   ps_control          bit0 kick half A, bit1 kick half B (registered levels)
//   pl_status           bit0 done-A pulse, bit1 done-B pulse
//   bram_*_y_b          y BRAM port B (drain + zero-on-read)
//   m_axis_*            AXI4-Stream of drained y words, tlast per half
// -----------------------------------------------------------------------------
module mv_host_sequencer
    import mvm_pkg::*;
#(
    parameter int addr_y_size = ADDR_Y_SIZE_DEFAULT,
    parameter int length_M    = LENGTH_M_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [15:0]            num_passes,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            ps_control,
    input  logic [31:0]            pl_status,
    output logic [addr_y_size-1:0] bram_addr_y_b,
    input  logic [31:0]            bram_rddata_y_b,
    output logic [31:0]            bram_wrdata_y_b,
    output logic [3:0]             bram_we_y_b,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast
);

    seq_state_t  state;
    logic [15:0] cnt;
    logic        seen_a;
    logic        seen_b;
    logic [1:0]  kick;
    logic        drain_go;
    logic        drain_half;
    logic        drain_finished;

    // Only the two done pulses are meaningful; the rest of the word is
    // reserved by the accelerator.
    logic unused_status_bits;
    assign unused_status_bits = ^pl_status[31:2];

    assign ps_control = {30'b0, kick};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            seen_a     <= 1'b0;
            seen_b     <= 1'b0;
            kick       <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            drain_go   <= 1'b0;
            drain_half <= HALF_A;
        end else begin
            done     <= 1'b0;
            drain_go <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_passes == 16'd0) begin
                            done <= 1'b1;
                        end else begin
                            cnt          <= num_passes;
                            kick[STAT_A] <= 1'b1;
                            busy         <= 1'b1;
                            state        <= WAIT_A;
                        end
                    end
                end
                // Kicking B here lets the accelerator compute B while A drains.
                WAIT_A: begin
                    if (seen_a) begin
                        seen_a       <= 1'b0;
                        kick[STAT_A] <= 1'b0;
                        kick[STAT_B] <= 1'b1;
                        drain_go     <= 1'b1;
                        drain_half   <= HALF_A;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_finished) begin
                        if (drain_half == HALF_A) begin
                            state <= WAIT_B;
                        end else if (cnt != 16'd0) begin
                            state <= WAIT_A;
                        end else begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= FINISH;
                        end
                    end
                end
                // A is already drained, so the next A kick is safe to raise
                // while B drains.
                WAIT_B: begin
                    if (seen_b) begin
                        seen_b       <= 1'b0;
                        kick[STAT_B] <= 1'b0;
                        cnt          <= cnt - 16'd1;
                        if (cnt != 16'd1) begin
                            kick[STAT_A] <= 1'b1;
                        end
                        drain_go     <= 1'b1;
                        drain_half   <= HALF_B;
                        state        <= DRAIN;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase

            // Placed after the case so a pulse arriving in the clearing cycle
            // wins over the clear.
            if (pl_status[STAT_A]) seen_a <= 1'b1;
            if (pl_status[STAT_B]) seen_b <= 1'b1;
        end
    end

    y_half_drainer #(
        .addr_y_size(addr_y_size),
        .length_M   (length_M)
    ) u_drainer (
        .clk            (clk),
        .reset          (reset),
        .go             (drain_go),
        .half_sel       (drain_half),
        .finished       (drain_finished),
        .bram_addr_y_b  (bram_addr_y_b),
        .bram_rddata_y_b(bram_rddata_y_b),
        .bram_wrdata_y_b(bram_wrdata_y_b),
        .bram_we_y_b    (bram_we_y_b),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast)
    );

endmodule

// File: tb/tb_mv_host_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mv_host_sequencer
//   Bench for mv_host_sequencer with length_M=8: behavioural y BRAM, an
//   accelerator stub that fills a half and pulses pl_status some cycles after
//   each kick, and a scoreboard of expected stream words filled by the stub.
// -----------------------------------------------------------------------------
module tb_mv_host_sequencer;

    localparam int AW = 12;
    localparam int M  = 8;

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    typedef struct {
        int np;
        bit stall;
        int da;
        int db;
        int words;
        int lasts;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   num_passes;
    logic          busy;
    logic          done;
    logic [31:0]   ps_control;
    logic [31:0]   pl_status;
    logic [AW-1:0] bram_addr_y_b;
    logic [31:0]   bram_rddata_y_b;
    logic [31:0]   bram_wrdata_y_b;
    logic [3:0]    bram_we_y_b;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    exp_t        sb[$];
    logic [31:0] mem[M];
    int          delay_a = 3;
    int          delay_b = 6;
    int          timer_a = -1;
    int          timer_b = -1;
    int          seq_a   = 0;
    int          seq_b   = 0;
    logic [1:0]  kick_prev;

    int          hs_count    = 0;
    int          tlast_count = 0;
    int          kicks_a     = 0;
    int          last_hs_cyc = 0;
    logic        hold_pending = 1'b0;
    logic [31:0] held_data;
    logic        a_undrained = 1'b0;
    logic [1:0]  ps_prev = 2'b00;

    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mv_host_sequencer #(
        .addr_y_size(AW),
        .length_M   (M)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_passes     (num_passes),
        .busy           (busy),
        .done           (done),
        .ps_control     (ps_control),
        .pl_status      (pl_status),
        .bram_addr_y_b  (bram_addr_y_b),
        .bram_rddata_y_b(bram_rddata_y_b),
        .bram_wrdata_y_b(bram_wrdata_y_b),
        .bram_we_y_b    (bram_we_y_b),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fill_word(input int half, input int seq, input int i);
        return 32'hA500_0000 | 32'(half << 16) | 32'((seq & 255) << 8) | 32'(i);
    endfunction

    // Behavioural y BRAM (port B, 1-cycle read) plus accelerator stub: a kick
    // edge arms a timer; on expiry the half is filled, its words are queued as
    // the expected stream, and the done pulse is raised for one cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < M; i++) mem[i] <= 32'hDEAD_0000 | 32'(i);
            timer_a         <= -1;
            timer_b         <= -1;
            pl_status       <= '0;
            kick_prev       <= 2'b00;
            bram_rddata_y_b <= '0;
        end else begin
            pl_status       <= '0;
            bram_rddata_y_b <= mem[bram_addr_y_b[4:2]];
            if (bram_we_y_b == 4'hf) mem[bram_addr_y_b[4:2]] <= bram_wrdata_y_b;

            if (ps_control[0] && !kick_prev[0]) timer_a <= delay_a;
            else if (timer_a > 0) timer_a <= timer_a - 1;
            else if (timer_a == 0) begin
                for (int i = 0; i < M / 2; i++) begin
                    mem[i] <= fill_word(0, seq_a, i);
                    sb.push_back('{data: fill_word(0, seq_a, i), addr: AW'(i * 4), last: (i == M / 2 - 1)});
                end
                seq_a        <= seq_a + 1;
                pl_status[0] <= 1'b1;
                timer_a      <= -1;
            end

            if (ps_control[1] && !kick_prev[1]) timer_b <= delay_b;
            else if (timer_b > 0) timer_b <= timer_b - 1;
            else if (timer_b == 0) begin
                for (int i = 0; i < M / 2; i++) begin
                    mem[M / 2 + i] <= fill_word(1, seq_b, i);
                    sb.push_back('{data: fill_word(1, seq_b, i), addr: AW'((M / 2 + i) * 4), last: (i == M / 2 - 1)});
                end
                seq_b        <= seq_b + 1;
                pl_status[1] <= 1'b1;
                timer_b      <= -1;
            end
            kick_prev <= ps_control[1:0];
        end
    end

    // Stream / BRAM-write / kick monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            hold_pending <= 1'b0;
            a_undrained  <= 1'b0;
            ps_prev      <= ps_control[1:0];
        end else begin
            if (hold_pending) begin
                check("hold_tvalid", {31'b0, m_axis_tvalid}, 32'h1);
                check("hold_tdata", m_axis_tdata, held_data);
            end
            hold_pending <= m_axis_tvalid && !m_axis_tready;
            held_data    <= m_axis_tdata;

            check("we_only_on_handshake", {28'b0, bram_we_y_b},
                  (m_axis_tvalid && m_axis_tready) ? 32'hf : 32'h0);

            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_underflow: got word 0x%08h at addr 0x%03h, want none", m_axis_tdata, bram_addr_y_b);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("stream_data", m_axis_tdata, e.data);
                    check("stream_addr", {20'b0, bram_addr_y_b}, {20'b0, e.addr});
                    check("stream_tlast", {31'b0, m_axis_tlast}, {31'b0, e.last});
                    check("clear_wrdata", bram_wrdata_y_b, 32'h0);
                    if (e.last && e.addr == AW'((M / 2 - 1) * 4)) a_undrained <= 1'b0;
                end
                hs_count    <= hs_count + 1;
                last_hs_cyc <= cyc;
                if (m_axis_tlast) tlast_count <= tlast_count + 1;
            end

            if (ps_control[0] && !ps_prev[0]) begin
                kicks_a <= kicks_a + 1;
                check("kickA_while_A_undrained", {31'b0, a_undrained}, 32'h0);
                check("kickA_value", ps_control, 32'h1);
            end
            if (!ps_control[0] && ps_prev[0]) a_undrained <= 1'b1;
            if (ps_control[1] && !ps_prev[1]) check("kickB_value", ps_control, 32'h2);
            ps_prev <= ps_control[1:0];
        end
    end

    task automatic run_job(input vec_t v, input string tag);
        int hs0, tl0, k0, done_c;
        bit got, stalled;
        hs0     = hs_count;
        tl0     = tlast_count;
        k0      = kicks_a;
        got     = 1'b0;
        stalled = 1'b0;
        done_c  = -1;
        delay_a = v.da;
        delay_b = v.db;

        num_passes = 16'(v.np);
        start      = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, {31'b0, busy}, {31'b0, (v.np != 0)});

        for (int c = 0; c < 3000 && !got; c++) begin
            if (done) begin
                got    = 1'b1;
                done_c = c;
            end else begin
                if (v.stall && !stalled && (hs_count - hs0) >= 2 && m_axis_tvalid) begin
                    m_axis_tready = 1'b0;
                    repeat (5) tick();
                    m_axis_tready = 1'b1;
                    stalled = 1'b1;
                end
                tick();
            end
        end
        check({tag, "_done_seen"}, {31'b0, got}, 32'h1);
        if (got) begin
            check({tag, "_busy_at_done"}, {31'b0, busy}, 32'h0);
            if (v.np == 0) check({tag, "_done_latency"}, done_c, 0);
            else           check({tag, "_done_after_last_hs"}, cyc - last_hs_cyc, 1);
            tick();
            check({tag, "_done_pulse_width"}, {31'b0, done}, 32'h0);
        end
        repeat (3) tick();
        check({tag, "_words"}, hs_count - hs0, v.words);
        check({tag, "_tlasts"}, tlast_count - tl0, v.lasts);
        check({tag, "_kicksA"}, kicks_a - k0, v.np);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle_ps"}, ps_control, 32'h0);
        if (v.np != 0) begin
            for (int i = 0; i < M; i++) check({tag, $sformatf("_zeroed%0d", i)}, mem[i], 32'h0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'h0);
        check({tag, "_done"}, {31'b0, done}, 32'h0);
        check({tag, "_ps_control"}, ps_control, 32'h0);
        check({tag, "_tvalid"}, {31'b0, m_axis_tvalid}, 32'h0);
        check({tag, "_tlast"}, {31'b0, m_axis_tlast}, 32'h0);
        check({tag, "_tdata"}, m_axis_tdata, 32'h0);
        check({tag, "_we"}, {28'b0, bram_we_y_b}, 32'h0);
        check({tag, "_addr"}, {20'b0, bram_addr_y_b}, 32'h0);
        check({tag, "_wrdata"}, bram_wrdata_y_b, 32'h0);
    endtask

    initial begin
        int  hs0;
        bit  got;

        //            np stall da db words lasts
        vecs[0] = '{np: 1, stall: 0, da: 3, db: 6, words:  8, lasts: 2};  // basic pass
        vecs[1] = '{np: 0, stall: 0, da: 3, db: 6, words:  0, lasts: 0};  // empty job
        vecs[2] = '{np: 1, stall: 1, da: 3, db: 6, words:  8, lasts: 2};  // back-pressure
        vecs[3] = '{np: 1, stall: 0, da: 3, db: 1, words:  8, lasts: 2};  // B done during A drain
        vecs[4] = '{np: 2, stall: 0, da: 3, db: 6, words: 16, lasts: 4};  // two passes
        vecs[5] = '{np: 3, stall: 1, da: 2, db: 1, words: 24, lasts: 6};  // overlap + stall

        reset         = 1'b1;
        start         = 1'b0;
        num_passes    = '0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) run_job(vecs[v], $sformatf("job%0d", v));

        // Abort mid-drain: the reset cycle must not clear the word on offer,
        // everything is zero afterwards, and a fresh job starts from addr 0.
        delay_a    = 3;
        delay_b    = 6;
        hs0        = hs_count;
        num_passes = 16'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 500 && !got; c++) begin
            if ((hs_count - hs0) >= 2 && m_axis_tvalid) got = 1'b1;
            else tick();
        end
        check("abort_reached_drain", {31'b0, got}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_write_in_reset_cycle", {28'b0, bram_we_y_b}, 32'h0);
        tick();
        check_all_zero("abort");
        repeat (2) tick();
        sb.delete();
        reset = 1'b0;
        tick();
        run_job(vecs[0], "post_abort");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
